uart_alu_interface: RTL and testbench
=====================================

Name: uart_alu_interface

Overview:
- Control stage between the UART receiver/transmitter and the combinational ALU.
- Assembles three received bytes, in the order operand A, operand B, opcode, into registered ALU inputs.
- One cycle after the opcode loads, captures the ALU result and launches it to the UART transmitter, then waits for transmit completion.
- Holds operands stable between transactions so the ALU output is always defined.

Parameters:
NB_DATA, 8, width of UART bytes, operands and ALU result
NB_OPCODE, 6, ALU opcode width; taken from rx byte bits [NB_OPCODE-1:0]
TIMEOUT_CYCLES, 100000000, inter-byte timeout in clocks (only with ALU_IF_TIMEOUT_EN)
NB_TIMEOUT, 27, timeout counter width; must satisfy 2^NB_TIMEOUT > TIMEOUT_CYCLES

Ports:
i_clk  input  1  system clock, rising edge
i_reset  input  1  synchronous reset, active-high
i_rx_data  input  NB_DATA  received byte, valid when i_rx_done=1
i_rx_done  input  1  one-cycle pulse: byte received
i_alu_result  input  NB_DATA  result from ALU, combinational from o_op_A/o_op_B/o_opcode
i_tx_done  input  1  one-cycle pulse: transmitter finished byte
o_op_A  output  NB_DATA  registered operand A to ALU
o_op_B  output  NB_DATA  registered operand B to ALU
o_opcode  output  NB_OPCODE  registered opcode to ALU
o_tx_data  output  NB_DATA  byte to transmit, stable from o_tx_start until i_tx_done
o_tx_start  output  1  one-cycle pulse: start transmission
o_busy  output  1  high in states SEND and WAIT_TX
o_timeout  output  1  one-cycle pulse: partial frame discarded

Behaviour:
- Single clock domain: i_clk. Reset is synchronous and active-high on i_reset; all registers update on the i_clk rising edge.
- Reset values: state=WAIT_A. o_op_A, o_op_B, o_opcode, o_tx_data, o_tx_start, o_busy, o_timeout and the timeout counter all 0.
- Reset mid-transaction aborts immediately: no o_tx_start is issued and partially received bytes are discarded.
- FSM states: WAIT_A, WAIT_B, WAIT_OP, SEND, WAIT_TX.
- WAIT_A: i_rx_done=1 -> o_op_A<=i_rx_data, go to WAIT_B.
- WAIT_B: i_rx_done=1 -> o_op_B<=i_rx_data, go to WAIT_OP.
- WAIT_OP: i_rx_done=1 -> o_opcode<=i_rx_data[NB_OPCODE-1:0], go to SEND. Upper bits [NB_DATA-1:NB_OPCODE] are discarded.
- SEND: lasts exactly one cycle, during which the ALU output settles. On exit: o_tx_data<=i_alu_result, o_tx_start<=1 for exactly one cycle, go to WAIT_TX.
- WAIT_TX: i_tx_done=1 -> go to WAIT_A.
- Latency: opcode i_rx_done sampled at edge N -> o_opcode valid after N -> o_tx_start high during the cycle following edge N+1.
- i_rx_done in SEND or WAIT_TX is ignored; the byte is dropped and no register changes.
- i_tx_done outside WAIT_TX is ignored.
- o_op_A, o_op_B and o_opcode hold their values until overwritten by a new byte; they are not cleared after a transaction.
- o_tx_data holds until the next SEND.
- o_busy is decoded from the registered state (SEND or WAIT_TX).
- Invalid opcodes are passed through unchanged; the ALU returns 0 for them and that 0 is transmitted.

Optional Feature:
- Macro: ALU_IF_TIMEOUT_EN.
- Defined:
  - Counter clears on entry to WAIT_A and on every accepted byte; it increments each cycle in WAIT_B and WAIT_OP.
  - When the counter equals TIMEOUT_CYCLES-1 with no i_rx_done that cycle: state<=WAIT_A, o_timeout pulses 1 cycle, counter clears, operand registers keep their values.
  - If i_rx_done and expiry coincide, the byte wins and no timeout occurs.
  - No timeout applies in WAIT_A, SEND or WAIT_TX.
- Undefined: no counter logic is built, o_timeout is tied to 0, and the FSM waits indefinitely for bytes.

Test Plan:
- Reset, then rx bytes 0x05, 0x03, 0x20 (ADD) -> o_op_A=0x05, o_op_B=0x03, o_opcode=0x20; exactly one o_tx_start pulse with o_tx_data=0x08 one cycle after SEND; o_busy=1 until i_tx_done.
- Bytes 0xF0, 0x02, 0x03 (SRA) with ALU model -> o_tx_data=0xFC. Opcode byte 0xE2 -> o_opcode=0x22 (upper bits discarded).
- Extra i_rx_done (0x55) during WAIT_TX -> ignored; next frame 0x01, 0x01, 0x22 -> o_op_A=0x01 and o_tx_data=0x00.
- i_reset asserted for 1 cycle after byte A=0x07 and byte B=0x09 -> all outputs 0, state WAIT_A, no o_tx_start; the following full frame processes normally.
- With ALU_IF_TIMEOUT_EN and TIMEOUT_CYCLES=16:
  - Send A, then idle 16 cycles -> o_timeout pulses once and the next byte loads o_op_A.
  - i_rx_done exactly on the expiry cycle -> byte accepted, no o_timeout.
- Without ALU_IF_TIMEOUT_EN: send A, idle 1000 cycles -> o_timeout stays 0, and the next byte loads o_op_B.

Source files
------------

// File: rtl/uart_alu_interface.sv
// rtl/uart_alu_interface.sv - assembles A/B/opcode bytes for the ALU and launches the result to the UART tx
// Optional inter-byte timeout is built only when ALU_IF_TIMEOUT_EN is defined.
module uart_alu_interface #(
  parameter int NB_DATA        = 8,
  parameter int NB_OPCODE      = 6,
  parameter int TIMEOUT_CYCLES = 100000000,
  parameter int NB_TIMEOUT     = 27
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [NB_DATA-1:0]   i_rx_data,
  input  logic                 i_rx_done,
  input  logic [NB_DATA-1:0]   i_alu_result,
  input  logic                 i_tx_done,
  output logic [NB_DATA-1:0]   o_op_A,
  output logic [NB_DATA-1:0]   o_op_B,
  output logic [NB_OPCODE-1:0] o_opcode,
  output logic [NB_DATA-1:0]   o_tx_data,
  output logic                 o_tx_start,
  output logic                 o_busy,
  output logic                 o_timeout
);

  typedef enum logic [2:0] {
    WAIT_A,
    WAIT_B,
    WAIT_OP,
    SEND,
    WAIT_TX
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic                 w_accept;
  logic                 w_timeout;
  logic [NB_DATA-1:0]   r_op_a;
  logic [NB_DATA-1:0]   r_op_b;
  logic [NB_OPCODE-1:0] r_opcode;
  logic [NB_DATA-1:0]   r_tx_data;
  logic                 r_tx_start;

  if (64'(TIMEOUT_CYCLES) >= (64'd1 << NB_TIMEOUT)) begin : g_timeout_width_check
    $error("NB_TIMEOUT too narrow for TIMEOUT_CYCLES");
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= WAIT_A;
    else         r_state <= w_next_state;
  end

  // A pending byte always beats a coinciding timeout expiry.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    case (r_state)
      WAIT_A: begin
        if (i_rx_done) begin
          w_accept     = 1'b1;
          w_next_state = WAIT_B;
        end
      end
      WAIT_B: begin
        if (i_rx_done) begin
          w_accept     = 1'b1;
          w_next_state = WAIT_OP;
        end else if (w_timeout) begin
          w_next_state = WAIT_A;
        end
      end
      WAIT_OP: begin
        if (i_rx_done) begin
          w_accept     = 1'b1;
          w_next_state = SEND;
        end else if (w_timeout) begin
          w_next_state = WAIT_A;
        end
      end
      SEND:    w_next_state = WAIT_TX;
      WAIT_TX: if (i_tx_done) w_next_state = WAIT_A;
      default: w_next_state = WAIT_A;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_opcode   <= '0;
      r_tx_data  <= '0;
      r_tx_start <= 1'b0;
    end else begin
      r_tx_start <= 1'b0;
      if (w_accept) begin
        case (r_state)
          WAIT_A:  r_op_a   <= i_rx_data;
          WAIT_B:  r_op_b   <= i_rx_data;
          default: r_opcode <= i_rx_data[NB_OPCODE-1:0];
        endcase
      end
      // The ALU has had the whole SEND cycle to settle on the new opcode.
      if (r_state == SEND) begin
        r_tx_data  <= i_alu_result;
        r_tx_start <= 1'b1;
      end
    end
  end

`ifdef ALU_IF_TIMEOUT_EN
  localparam logic [NB_TIMEOUT-1:0] TIMEOUT_LAST = NB_TIMEOUT'(TIMEOUT_CYCLES - 1);

  logic [NB_TIMEOUT-1:0] r_timer;
  logic                  r_timeout;

  assign w_timeout = ((r_state == WAIT_B) || (r_state == WAIT_OP)) &&
                     !i_rx_done && (r_timer == TIMEOUT_LAST);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_timer   <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_timeout;
      if (w_accept || (w_next_state == WAIT_A))
        r_timer <= '0;
      else if ((r_state == WAIT_B) || (r_state == WAIT_OP))
        r_timer <= r_timer + 1'b1;
    end
  end

  assign o_timeout = r_timeout;
`else
  assign w_timeout = 1'b0;
  assign o_timeout = 1'b0;
`endif

  assign o_op_A     = r_op_a;
  assign o_op_B     = r_op_b;
  assign o_opcode   = r_opcode;
  assign o_tx_data  = r_tx_data;
  assign o_tx_start = r_tx_start;
  assign o_busy     = (r_state == SEND) || (r_state == WAIT_TX);

endmodule

// File: tb/tb_uart_alu_interface.sv
// tb/tb_uart_alu_interface.sv - randomized self-checking bench for uart_alu_interface
// Timeout checks are compiled in when ALU_IF_TIMEOUT_EN is defined.
module tb_uart_alu_interface;

  localparam int NB_DATA   = 8;
  localparam int NB_OPCODE = 6;
  localparam int TO_CYCLES = 16;
`ifdef ALU_IF_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 i_reset = 1'b1;
  logic [NB_DATA-1:0]   i_rx_data = '0;
  logic                 i_rx_done = 1'b0;
  logic [NB_DATA-1:0]   i_alu_result;
  logic                 i_tx_done = 1'b0;
  logic [NB_DATA-1:0]   o_op_A;
  logic [NB_DATA-1:0]   o_op_B;
  logic [NB_OPCODE-1:0] o_opcode;
  logic [NB_DATA-1:0]   o_tx_data;
  logic                 o_tx_start;
  logic                 o_busy;
  logic                 o_timeout;

  int n_checks = 0;
  int n_errors = 0;
  bit done = 1'b0;

  uart_alu_interface #(
    .NB_DATA(NB_DATA), .NB_OPCODE(NB_OPCODE),
    .TIMEOUT_CYCLES(TO_CYCLES), .NB_TIMEOUT(5)
  ) dut (
    .i_clk(clk), .i_reset(i_reset), .i_rx_data(i_rx_data), .i_rx_done(i_rx_done),
    .i_alu_result(i_alu_result), .i_tx_done(i_tx_done),
    .o_op_A(o_op_A), .o_op_B(o_op_B), .o_opcode(o_opcode), .o_tx_data(o_tx_data),
    .o_tx_start(o_tx_start), .o_busy(o_busy), .o_timeout(o_timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h27:   return ~(a | b);
      6'h03:   return 8'($signed(a) >>> b);
      6'h02:   return a >> b;
      default: return 8'h00;
    endcase
  endfunction

  assign i_alu_result = alu_f(o_op_A, o_op_B, o_opcode);

  // Reference model: counts bytes of the current frame and tracks the transaction in flight.
  logic [7:0] e_a = 0, e_b = 0, e_tx = 0;
  logic [5:0] e_op = 0;
  bit e_start = 0, e_busy = 0, e_to = 0, m_send_pending = 0;
  int m_nbytes = 0, m_idle = 0;

  always @(posedge clk) begin
    if (i_reset) begin
      e_a = 0; e_b = 0; e_op = 0; e_tx = 0;
      e_start = 0; e_busy = 0; e_to = 0; m_send_pending = 0;
      m_nbytes = 0; m_idle = 0;
    end else begin
      e_start = 0;
      e_to    = 0;
      if (!e_busy) begin
        if (i_rx_done) begin
          if (m_nbytes == 0)      e_a  = i_rx_data;
          else if (m_nbytes == 1) e_b  = i_rx_data;
          else                    e_op = i_rx_data[5:0];
          m_idle = 0;
          if (m_nbytes == 2) begin
            m_nbytes = 0;
            e_busy = 1;
            m_send_pending = 1;
          end else begin
            m_nbytes++;
          end
        end else if (TO_EN && m_nbytes > 0) begin
          m_idle++;
          if (m_idle == TO_CYCLES) begin
            m_nbytes = 0;
            m_idle = 0;
            e_to = 1;
          end
        end
      end else if (m_send_pending) begin
        m_send_pending = 0;
        e_start = 1;
        e_tx = alu_f(e_a, e_b, e_op);
      end else if (i_tx_done) begin
        e_busy = 0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: actual 0x%0h required 0x%0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!done) begin
      chk("op_A", o_op_A, e_a);
      chk("op_B", o_op_B, e_b);
      chk("opcode", o_opcode, e_op);
      chk("tx_data", o_tx_data, e_tx);
      chk("tx_start", o_tx_start, e_start);
      chk("busy", o_busy, e_busy);
      chk("timeout", o_timeout, e_to);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    i_rx_data = b;
    i_rx_done = 1'b1;
    @(negedge clk);
    i_rx_done = 1'b0;
    i_rx_data = 8'($urandom);
  endtask

  task automatic gap(input int max_n);
    int n;
    n = $urandom_range(0, max_n);
    repeat (n) begin
      i_tx_done = ($urandom_range(0, 5) == 0);
      @(negedge clk);
    end
    i_tx_done = 1'b0;
  endtask

  task automatic wait_start(input string name, input logic [7:0] exp);
    int n;
    n = 0;
    while (!o_tx_start && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_latency"}, n, 1);
    chk({name, "_data"}, o_tx_data, exp);
  endtask

  task automatic tx_complete();
    repeat ($urandom_range(0, 4)) @(negedge clk);
    i_tx_done = 1'b1;
    @(negedge clk);
    i_tx_done = 1'b0;
  endtask

  task automatic frame(input string name, input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                       input logic [7:0] exp);
    send_byte(a);
    gap(3);
    send_byte(b);
    gap(3);
    send_byte(op);
    wait_start(name, exp);
    tx_complete();
  endtask

  initial begin
    logic [7:0] ops [8];
    logic [7:0] a, b, op;
    int cnt;
    ops = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h03, 8'h02};

    repeat (3) @(negedge clk);
    chk("rst_op_A", o_op_A, 0);
    chk("rst_tx_start", o_tx_start, 0);
    chk("rst_busy", o_busy, 0);
    i_reset = 1'b0;

    frame("add", 8'h05, 8'h03, 8'h20, 8'h08);
    chk("add_op_A", o_op_A, 8'h05);
    chk("add_op_B", o_op_B, 8'h03);
    chk("add_opcode", o_opcode, 6'h20);
    frame("sra", 8'hF0, 8'h02, 8'h03, 8'hFC);
    frame("sub_masked", 8'h10, 8'h04, 8'hE2, 8'h0C);
    chk("masked_opcode", o_opcode, 6'h22);

    send_byte(8'h0A);
    send_byte(8'h0B);
    send_byte(8'h25);
    wait_start("or", 8'h0B);
    send_byte(8'h55);
    chk("stray_rx_op_A", o_op_A, 8'h0A);
    tx_complete();
    frame("sub_zero", 8'h01, 8'h01, 8'h22, 8'h00);
    chk("sub_zero_op_A", o_op_A, 8'h01);

    send_byte(8'h07);
    send_byte(8'h09);
    i_reset = 1'b1;
    @(negedge clk);
    i_reset = 1'b0;
    chk("midrst_op_A", o_op_A, 0);
    chk("midrst_op_B", o_op_B, 0);
    chk("midrst_busy", o_busy, 0);
    frame("post_reset", 8'h12, 8'h34, 8'h20, 8'h46);

`ifdef ALU_IF_TIMEOUT_EN
    send_byte(8'h11);
    cnt = 0;
    repeat (20) begin
      if (o_timeout) cnt++;
      @(negedge clk);
    end
    chk("timeout_pulses", cnt, 1);
    send_byte(8'h33);
    chk("after_timeout_op_A", o_op_A, 8'h33);
    send_byte(8'h44);
    send_byte(8'h20);
    wait_start("after_timeout", 8'h77);
    tx_complete();

    send_byte(8'h21);
    repeat (TO_CYCLES - 1) @(negedge clk);
    send_byte(8'h22);
    chk("coincide_op_B", o_op_B, 8'h22);
    chk("coincide_no_timeout", o_timeout, 0);
    send_byte(8'h24);
    wait_start("coincide", 8'h20);
    tx_complete();
`else
    send_byte(8'h61);
    cnt = 0;
    repeat (1000) begin
      if (o_timeout) cnt++;
      @(negedge clk);
    end
    chk("no_timeout_pulses", cnt, 0);
    send_byte(8'h62);
    chk("no_timeout_op_B", o_op_B, 8'h62);
    send_byte(8'h26);
    wait_start("no_timeout", 8'h03);
    tx_complete();
`endif

    for (int i = 0; i < 40; i++) begin
      a  = 8'($urandom);
      b  = 8'($urandom);
      op = ($urandom_range(0, 4) == 0) ? 8'($urandom) : ops[$urandom_range(0, 7)];
      send_byte(a);
      gap(4);
      send_byte(b);
      gap(4);
      send_byte(op);
      wait_start("rand", alu_f(a, b, op[5:0]));
      if ($urandom_range(0, 2) == 0) send_byte(8'($urandom));
      tx_complete();
      gap(4);
    end

    @(negedge clk);
    done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    if (!done) begin
      done = 1'b1;
      n_errors++;
      $display("FAIL watchdog at %0t: actual running required finished", $time);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
    end
  end

endmodule
